// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the master and the slave endpoints.
package spi_pkg;

  localparam int                    SPI_WIDTH      = 8;
  localparam logic [SPI_WIDTH-1:0]  SPI_DEFAULT_TX = 8'h00;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// SPI input stage: optional 2-flop synchronisers (macro SPI_SLAVE_SYNC_EN)
// followed by a one-cycle delay register used to decode sclk/cs_n edges.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic rise,
  output logic fall,
  output logic sel_start,
  output logic sel_end,
  output logic mosi_s
);

  logic sclk_s;
  logic cs_s;
  logic sclk_prev_q, sclk_prev_d;
  logic cs_prev_q, cs_prev_d;

`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  // Shift each raw input one stage further through its synchroniser chain.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], sclk};
    cs_sync_d   = {cs_sync_q[0], cs_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
  end

  // Synchroniser flops; chip select resets to the deselected level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
`else
  // Same-clock master: its outputs are already registered on clk.
  assign sclk_s = sclk;
  assign cs_s   = cs_n;
  assign mosi_s = mosi;
`endif

  // Previous-cycle copies of sclk and chip select for edge detection.
  always_comb begin
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  // Delay register; cs resets high so no select edge appears out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign rise      =  sclk_s & ~sclk_prev_q & ~cs_s;
  assign fall      = ~sclk_s &  sclk_prev_q & ~cs_s;
  assign sel_start = ~cs_s   &  cs_prev_q;
  assign sel_end   =  cs_s   & ~cs_prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: MSB-first receive into rx_data, transmit from a
// one-entry valid/ready holding register. Optional input synchronisers are
// enabled with the macro SPI_SLAVE_SYNC_EN (see spi_edge_sync).
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH      = SPI_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_TX = WIDTH'(SPI_DEFAULT_TX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam int CNT_W = $clog2(WIDTH);

  logic rise, fall, sel_start, sel_end, mosi_s;

  spi_edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .rise      (rise),
    .fall      (fall),
    .sel_start (sel_start),
    .sel_end   (sel_end),
    .mosi_s    (mosi_s)
  );

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  // Only WIDTH-1 bits are kept: the final bit arrives straight from mosi_s.
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic             miso_q, miso_d;
  logic             frame_err_q, frame_err_d;
  logic             underrun_q, underrun_d;

  logic             wr_accept;
  logic             load;
  logic [WIDTH-1:0] rx_word;

  assign wr_accept = tx_valid & ~hold_full_q;
  // New frame starts on select, or on the first fall after a completed
  // frame when chip select stays low.
  assign load      = sel_start |
                     ((state_q == SPI_ACTIVE) & fall & (bit_cnt_q == '0));
  assign rx_word   = {rx_shift_q, mosi_s};

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    frame_err_d = 1'b0;
    underrun_d  = underrun_q & ~underrun_clr;

    if (wr_accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_data_q;
        hold_full_d = 1'b0;
      end else if (wr_accept) begin
        // Write lands on the load cycle: bypass the empty holding register.
        tx_shift_d  = tx_data;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d  = DEFAULT_TX;
        underrun_d  = 1'b1;
      end
    end

    case (state_q)
      SPI_IDLE: begin
        bit_cnt_d = '0;
        if (sel_start) state_d = SPI_ACTIVE;
      end
      SPI_ACTIVE: begin
        if (sel_end) begin
          state_d    = SPI_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
          if (bit_cnt_q != '0) frame_err_d = 1'b1;
        end else begin
          if (rise) begin
            rx_shift_d = rx_word[WIDTH-2:0];
            if (bit_cnt_q == CNT_W'(WIDTH-1)) begin
              bit_cnt_d  = '0;
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (fall && (bit_cnt_q != '0)) begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    // Registered from the next shift value so the MSB is on miso the
    // cycle after the load, before the master's first sample.
    miso_d = (state_d == SPI_ACTIVE) ? tx_shift_d[WIDTH-1] : 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SPI_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = ~hold_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q == SPI_ACTIVE);
  assign frame_err = frame_err_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave (default build, same-clock master).
// The bench plays the SPI master and keeps a transaction-level model of
// the holding register, the sticky underrun flag and the last good frame.
module tb_spi_slave;

  localparam logic [7:0] DEF_TX = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       underrun;
  logic       underrun_clr = 1'b0;

  spi_slave #(.WIDTH(8), .DEFAULT_TX(DEF_TX)) dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .frame_err    (frame_err),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rxv_cnt = 0;
  int fe_cnt = 0;

  // Reference model state.
  logic [7:0] hold[$];
  logic       m_underrun = 1'b0;
  logic [7:0] m_rx = 8'h00;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt <= rxv_cnt + 1;
    if (frame_err) fe_cnt  <= fe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word the slave should load at frame start.
  task automatic model_load(input bit byp, input logic [7:0] bd, output logic [7:0] w);
    if (hold.size() > 0) w = hold.pop_front();
    else if (byp) w = bd;
    else begin
      w = DEF_TX;
      m_underrun = 1'b1;
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    check_eq("tx_ready_pre", tx_ready, hold.size() == 0);
    tx_valid = 1'b1;
    tx_data  = v;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (hold.size() == 0) hold.push_back(v);
    check_eq("tx_ready_post", tx_ready, 1'b0);
  endtask

  task automatic clr_underrun();
    underrun_clr = 1'b1;
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    m_underrun = 1'b0;
    check_eq("underrun_clr", underrun, 1'b0);
  endtask

  // Master-side bit engine: one rise then one fall per bit, toggling every
  // clk. On the last frame chip select rises together with the final fall.
  task automatic xfer(input logic [7:0] d, input int nbits, input bit first, input bit last,
                      input bit byp, input logic [7:0] bd, input bit refill,
                      input logic [7:0] rd, output logic [7:0] got);
    got = 8'h00;
    if (first) begin
      cs_n = 1'b0;
      sclk = 1'b0;
      if (byp) begin
        tx_valid = 1'b1;
        tx_data  = bd;
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = d[7-i];
      if (refill && i == 0) begin
        tx_valid = 1'b1;
        tx_data  = rd;
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
      got = {got[6:0], miso};
      sclk = 1'b0;
      if (last && i == nbits - 1) cs_n = 1'b1;
      @(posedge clk); #1;
    end
    if (last) begin
      @(posedge clk); #1;
    end
  endtask

  // One frame with model update and checks.
  task automatic exchange(input logic [7:0] d, input int nbits, input bit first, input bit last,
                          input bit byp, input logic [7:0] bd, input bit refill, input logic [7:0] rd);
    logic [7:0] exp_tx;
    logic [7:0] got;
    int         rxv0;
    int         fe0;
    rxv0 = rxv_cnt;
    fe0  = fe_cnt;
    model_load(byp && first, bd, exp_tx);
    if (refill && hold.size() == 0) hold.push_back(rd);
    xfer(d, nbits, first, last, byp && first, bd, refill, rd, got);
    if (nbits == 8) begin
      m_rx = d;
      check_eq("rx_data", rx_data, d);
      check_eq("rx_pulses", rxv_cnt - rxv0, 1);
      check_eq("miso_word", got, exp_tx);
      check_eq("no_frame_err", fe_cnt - fe0, 0);
    end else begin
      check_eq("rx_held", rx_data, m_rx);
      check_eq("rx_pulses_abort", rxv_cnt - rxv0, 0);
      check_eq("frame_err", fe_cnt - fe0, 1);
      check_eq("miso_part", got, exp_tx >> (8 - nbits));
    end
    if (last) begin
      check_eq("underrun", underrun, m_underrun);
      check_eq("tx_ready", tx_ready, hold.size() == 0);
      check_eq("busy_end", busy, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d, bd, rd, got;
    int         nfr, nb;
    bit         byp, refill, last;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_miso", miso, 1'b0);
    check_eq("rst_tx_ready", tx_ready, 1'b1);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic exchange.
    tx_write(8'hA5);
    exchange(8'h3C, 8, 1, 1, 0, 8'h00, 0, 8'h00);
    // Underrun, then clear.
    exchange(8'h81, 8, 1, 1, 0, 8'h00, 0, 8'h00);
    clr_underrun();
    // Bypass on the select cycle.
    exchange(8'h99, 8, 1, 1, 1, 8'h5A, 0, 8'h00);
    // Abort after three rises, then a good frame.
    tx_write(8'h6E);
    exchange(8'h47, 3, 1, 1, 0, 8'h00, 0, 8'h00);
    tx_write(8'h0F);
    exchange(8'hF0, 8, 1, 1, 0, 8'h00, 0, 8'h00);
    // Back-to-back with refill.
    tx_write(8'h55);
    exchange(8'h12, 8, 1, 0, 0, 8'h00, 1, 8'hAA);
    exchange(8'h34, 8, 0, 1, 0, 8'h00, 0, 8'h00);

    // Reset mid-frame.
    tx_write(8'h77);
    xfer(8'hE1, 4, 1, 0, 0, 8'h00, 0, 8'h00, got);
    rst  = 1'b1;
    cs_n = 1'b1;
    @(posedge clk); #1;
    check_eq("mrst_miso", miso, 1'b0);
    check_eq("mrst_rx_data", rx_data, 8'h00);
    check_eq("mrst_rx_valid", rx_valid, 1'b0);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_frame_err", frame_err, 1'b0);
    check_eq("mrst_underrun", underrun, 1'b0);
    check_eq("mrst_tx_ready", tx_ready, 1'b1);
    rst = 1'b0;
    hold.delete();
    m_underrun = 1'b0;
    m_rx = 8'h00;
    @(posedge clk); #1;
    tx_write(8'h3E);
    exchange(8'hC3, 8, 1, 1, 0, 8'h00, 0, 8'h00);

    // Randomised bursts.
    for (int b = 0; b < 40; b++) begin
      nfr = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      for (int f = 0; f < nfr; f++) begin
        d      = 8'($urandom);
        bd     = 8'($urandom);
        rd     = 8'($urandom);
        last   = (f == nfr - 1);
        nb     = (last && $urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
        byp    = (f == 0) && ($urandom_range(0, 2) == 0);
        refill = ($urandom_range(0, 1) == 1);
        exchange(d, nb, f == 0, last, byp, bd, refill, rd);
      end
      if ($urandom_range(0, 2) == 0) clr_underrun();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
